// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory request handshake,
// registered IF/ID output slot with a one-entry skid buffer for decode
// stalls, and a redirect path that flushes the slot and skid.
module instr_fetch_unit #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      if_opcode
);

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'd4};

    logic            started_q,    started_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic            if_valid_q,   if_valid_d;
    logic [XLEN-1:0] if_pc_q,      if_pc_d;
    logic [XLEN-1:0] if_instr_q,   if_instr_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;

    logic xfer;
    logic slot_free;

    // Request and output decode from registered state.
    always_comb begin
        imem_req    = started_q & ~skid_valid_q;
        imem_addr   = pc_q & WORD_MASK;
        xfer        = imem_req & imem_ready;
        slot_free   = ~if_valid_q | ~stall;
        if_valid    = if_valid_q;
        if_pc       = if_pc_q;
        if_pc_plus4 = if_pc_q + FOUR;
        if_instr    = if_instr_q;
        if_opcode   = if_instr_q[6:0];
    end

    // Next-state: redirect beats everything; otherwise advance PC on a
    // transfer and route the returned word into the slot or the skid.
    always_comb begin
        started_d    = 1'b1;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (redirect_valid) begin
            pc_d         = redirect_target & WORD_MASK;
            if_valid_d   = 1'b0;
            if_instr_d   = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else begin
            if (xfer) begin
                pc_d = pc_q + FOUR;
            end
            if (slot_free) begin
                if (skid_valid_q) begin
                    if_valid_d   = 1'b1;
                    if_pc_d      = skid_pc_q;
                    if_instr_d   = skid_instr_q;
                    skid_valid_d = 1'b0;
                end else if (xfer) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = imem_addr;
                    if_instr_d = imem_rdata;
                end else begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
            end else if (xfer) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = imem_addr;
                skid_instr_d = imem_rdata;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q    <= 1'b0;
            pc_q         <= RESET_PC & WORD_MASK;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            started_q    <= started_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: accepted fetches are queued in
// program order, decode consumption pops them, redirects flush them.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    logic        pat_mode;
    logic [31:0] rnd_data;

    always #5 clk = ~clk;

    // Memory returns either an address-derived pattern or random data.
    assign imem_rdata = pat_mode ? (imem_addr ^ 32'h5A00_0000) : rnd_data;

    instr_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_instr        (if_instr),
        .if_opcode       (if_opcode)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] exp_pc;
    logic        started_m;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/reference model: compare state left by the last edge, then
    // apply what the coming edge does to the instruction stream.
    always @(negedge clk) begin
        logic req_m;
        logic tr_m;
        ent_t h;
        if (reset) begin
            sb.delete();
            exp_pc    = RESET_PC;
            started_m = 1'b0;
            chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
            chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        end else begin
            req_m = started_m && (sb.size() < 2);
            chk("imem_req", {31'b0, imem_req}, {31'b0, req_m});
            chk("imem_addr", imem_addr, exp_pc);
            chk("if_valid", {31'b0, if_valid}, {31'b0, sb.size() > 0});
            if (sb.size() > 0) begin
                h = sb[0];
                chk("if_pc", if_pc, h.pc);
                chk("if_instr", if_instr, h.instr);
                chk("if_pc_plus4", if_pc_plus4, h.pc + 32'd4);
                chk("if_opcode", {25'b0, if_opcode}, {25'b0, h.instr[6:0]});
            end else begin
                chk("bubble_instr", if_instr, NOP);
                chk("bubble_opcode", {25'b0, if_opcode}, 32'h13);
            end

            tr_m = req_m && imem_ready;
            if (sb.size() > 0 && !stall) void'(sb.pop_front());
            if (redirect_valid) begin
                sb.delete();
                exp_pc = {redirect_target[31:2], 2'b00};
            end else if (tr_m) begin
                sb.push_back('{pc: exp_pc, instr: imem_rdata});
                exp_pc = exp_pc + 32'd4;
            end
            started_m = 1'b1;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        rnd_data = $urandom;
    endtask

    task automatic idle_inputs();
        imem_ready      = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
    endtask

    initial begin
        reset    = 1'b1;
        pat_mode = 1'b1;
        rnd_data = '0;
        idle_inputs();
        repeat (3) cycle();

        // Release: first valid two edges later, addresses stream 0,4,8...
        reset      = 1'b0;
        imem_ready = 1'b1;
        cycle();
        chk("first_req_low_then_valid0", {31'b0, if_valid}, 32'd0);
        cycle();
        chk("first_valid_latency", {31'b0, if_valid}, 32'd1);
        chk("first_if_pc", if_pc, RESET_PC);
        cycle();

        // Memory not ready for three cycles.
        imem_ready = 1'b0;
        repeat (3) cycle();
        imem_ready = 1'b1;
        repeat (2) cycle();

        // Decode stall for four cycles, then release.
        stall = 1'b1;
        repeat (4) cycle();
        stall = 1'b0;
        repeat (4) cycle();

        // Redirect to an unaligned target with skid full and stall high.
        stall = 1'b1;
        repeat (3) cycle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_flush", {31'b0, if_valid}, 32'd0);
        repeat (3) cycle();

        // Redirect coincident with an accepted request: pc is target, not target+4.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_2000;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_xfer_dropped", imem_addr, 32'h0000_2000);
        repeat (2) cycle();

        // PC wrap at the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        repeat (3) cycle();

        // Randomized traffic.
        pat_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            imem_ready     = ($urandom_range(99) < 75);
            stall          = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        // Asynchronous reset pulse in the middle of a stall.
        pat_mode   = 1'b1;
        imem_ready = 1'b1;
        stall      = 1'b1;
        repeat (4) cycle();
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, if_valid}, 32'd0);
        chk("async_rst_req", {31'b0, imem_req}, 32'd0);
        chk("async_rst_addr", imem_addr, RESET_PC);
        cycle();
        reset = 1'b0;
        stall = 1'b0;
        cycle();
        cycle();
        chk("restart_valid", {31'b0, if_valid}, 32'd1);
        chk("restart_pc", if_pc, RESET_PC);
        repeat (5) cycle();

        idle_inputs();
        repeat (4) cycle();
        chk("drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage of the 32-bit core, directly upstream of the main controller.
- Holds the PC, issues word requests to instruction memory over a req/ready handshake, and registers the returned instruction into an IF/ID output slot.
- The slot's if_opcode feeds the controller's Opcode input.
- Provides a one-entry skid buffer for decode stalls and a redirect/flush path for taken branches and jumps.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented when the slot is empty

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch word address (equals pc)
imem_ready  input  1  memory accepts request; imem_rdata valid in the same cycle
imem_rdata  input  XLEN  fetched instruction
stall  input  1  decode cannot accept; hold the slot
redirect_valid  input  1  taken branch/jump; flush and refetch
redirect_target  input  XLEN  new PC
if_valid  output  1  slot holds a real instruction
if_pc  output  XLEN  PC of the slot instruction
if_pc_plus4  output  XLEN  if_pc + 4 (jump link value)
if_instr  output  XLEN  slot instruction, NOP_INSTR when !if_valid
if_opcode  output  7  if_instr[6:0], to the controller

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, started=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, skid_valid=0. imem_req drops in the same cycle reset asserts.
- started flop: set on the first clock edge after reset deasserts. Result: imem_req=0 during the first post-reset cycle.
- imem_req = started & !skid_valid. imem_addr = {pc[XLEN-1:2],2'b00}.
- Transfer: t = imem_req & imem_ready. The address is held stable until t, except on redirect; instruction memory tolerates abandoned unaccepted requests.
- Priority per clock edge, highest first:
  1. redirect_valid:
     - pc <= {redirect_target[XLEN-1:2],2'b00}
     - if_valid <= 0, if_instr <= NOP_INSTR, skid_valid <= 0
     - any transfer in the same cycle is discarded; pc is not incremented
     - overrides stall
  2. Otherwise, if t: pc <= pc + 4. Wrap-around is modulo 2^XLEN with no error.
  3. Slot free (!if_valid | !stall):
     - if skid_valid: slot <= skid contents, skid_valid <= 0
     - else if t: slot <= {pc, imem_rdata}, if_valid <= 1
     - else: if_valid <= 0, if_instr <= NOP_INSTR
  4. Slot held (if_valid & stall):
     - slot unchanged
     - if t: skid <= {pc, imem_rdata}, skid_valid <= 1; req then drops until the skid drains
- Latency and throughput:
  - Instruction appears on if_* the cycle after its transfer.
  - Sustained throughput is 1 instruction per cycle with imem_ready=1 and stall=0.
  - First if_valid is 2 cycles after reset release.
- Ordering: no instruction is lost or duplicated across stalls. Order is strictly PC order between redirects.
- stall while !if_valid: no effect; the slot loads normally.
- if_pc_plus4 is combinational from if_pc. if_opcode is combinational from if_instr.
- Reset asserted mid-request or mid-stall: all state clears immediately. Fetch restarts at RESET_PC.

Test Plan:
- Reset release, imem_ready=1, stall=0, rdata=addr-based pattern → imem_addr 0,4,8,... on consecutive cycles. First if_valid=1 2 cycles after release with if_pc=0. if_opcode tracks the pattern; if_pc_plus4=if_pc+4.
- imem_ready low 3 cycles at addr 0x8 → imem_addr held at 0x8. if_valid=0 with if_instr=0x00000013 and if_opcode=7'h13. Fetch resumes without skipping.
- stall high 4 cycles while slot holds 0x4 → slot frozen at 0x4, 0x8 captured in skid, imem_req low. After release, slot shows 0x4 then 0x8, then 0xC from the next fetch; no loss or duplication.
- redirect_valid with target 0x103 while skid full and stall high → next cycle imem_addr=0x100, if_valid=0, skid empty. First post-redirect if_pc=0x100.
- redirect coincident with imem_ready → that response dropped, pc=target, not target+4.
- pc=0xFFFF_FFFC fetch → next imem_addr=0x0. Async reset pulse mid-stall → if_valid and imem_req drop immediately; restart at RESET_PC.
